// File: rtl/mux_nt1_rr.sv
// mux_nt1_rr: N-input, n-bit stream multiplexer with per-channel valid/ready,
// one registered output stage (one cycle latency, full throughput).
//
// Configuration macro: MUX_RR_FAIR_EN
//   defined   -> round-robin arbitration starting at a rotating pointer PTR
//   undefined -> fixed priority (lowest valid index wins), no pointer state
module mux_nt1_rr #(
    parameter  int N    = 4,
    parameter  int n    = 32,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N*n-1:0]    D_IN,
    input  logic [N-1:0]      D_VALID,
    output logic [N-1:0]      D_READY,
    output logic [n-1:0]      D_OUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [SELW-1:0]   OUT_SEL
);

    // Output register is empty or is being drained this cycle.
    logic            load;
    logic            found;
    logic [SELW-1:0] gnt;
    int              idx;

`ifdef MUX_RR_FAIR_EN
    logic [SELW-1:0] ptr;
`endif

    assign load = !OUT_VALID || OUT_READY;

    // Pick the first valid channel, scanning from PTR (round-robin) or from 0.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
`ifdef MUX_RR_FAIR_EN
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
`else
            idx = i;
`endif
            if (!found && D_VALID[idx]) begin
                found = 1'b1;
                gnt   = SELW'(idx);
            end
        end
    end

    // Handshake back to the granted producer; reset suppresses it so a word
    // dropped by reset is never seen as transferred.
    always_comb begin
        D_READY = '0;
        if (!RST && found && load) D_READY[gnt] = 1'b1;
    end

    // Output register: load on grant, clear valid on drain, hold on stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            D_OUT     <= '0;
            OUT_SEL   <= '0;
            OUT_VALID <= 1'b0;
        end else if (load) begin
            if (found) begin
                D_OUT     <= D_IN[int'(gnt)*n +: n];
                OUT_SEL   <= gnt;
                OUT_VALID <= 1'b1;
            end else begin
                OUT_VALID <= 1'b0;
            end
        end
    end

`ifdef MUX_RR_FAIR_EN
    // Round-robin pointer: next scan starts just after the last winner,
    // wrapping explicitly so non-power-of-two N works.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (load && found) begin
            ptr <= (gnt == SELW'(N - 1)) ? '0 : gnt + SELW'(1);
        end
    end
`endif

endmodule

// File: doc/mux_nt1_rr.md
Name: mux_nt1_rr

Overview:
- Parametrised successor of the 2:1 mux: N-input, n-bit stream multiplexer with per-channel valid/ready handshake, round-robin arbitration and a registered output stage.
- Used where several producers share one consumer, e.g. multiple requesters into the memory/bus interface or writeback arbitration.
- Output is registered, so there is one cycle of latency. Full throughput: one transfer per cycle while the consumer is ready.

Parameters:
- N, 4, number of input channels (N >= 1).
- n, 32, data width per channel.
- SELW, $clog2(N) with a minimum of 1, channel-index width. Derived localparam; never overridden.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- D_IN  input  N*n  flattened channel data; channel k occupies bits [k*n +: n].
- D_VALID  input  N  per-channel valid.
- D_READY  output  N  per-channel ready. At most one bit is set per cycle.
- D_OUT  output  n  registered output data.
- OUT_VALID  output  1  output register holds valid data.
- OUT_READY  input  1  consumer ready.
- OUT_SEL  output  SELW  index of the channel whose data is in D_OUT.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - OUT_VALID=0, D_OUT=0, OUT_SEL=0, round-robin pointer PTR=0.
  - D_READY=0 while RST=1, regardless of D_VALID.
- Load enable: LOAD = !OUT_VALID | OUT_READY. The output register is empty or is being drained this cycle.
- Grant (combinational):
  - G = first k with D_VALID[k]=1, scanning PTR, PTR+1, ..., N-1, 0, ..., PTR-1 (mod N).
  - If no channel is valid, there is no grant.
- D_READY[G] = LOAD & D_VALID[G]. All other D_READY bits are 0. D_READY depends combinationally on D_VALID and OUT_READY.
- Transfer in (LOAD and a grant exist) at the clock edge:
  - D_OUT <= D_IN[G]; OUT_SEL <= G; OUT_VALID <= 1.
  - PTR <= G+1, wrapping to 0 when G=N-1. This wraps correctly for non-power-of-two N.
- Drain without refill (OUT_VALID & OUT_READY, no valid input): OUT_VALID <= 0. D_OUT and OUT_SEL hold their last value.
- Stall (OUT_VALID & !OUT_READY):
  - D_OUT, OUT_SEL, OUT_VALID and PTR hold.
  - All D_READY=0.
- Simultaneous drain and refill in the same cycle: the new word loads, and OUT_VALID stays 1 with no bubble.
- Idle (no D_VALID, OUT_VALID=0): all state holds.
- Reset mid-transfer: reset wins. The held word is dropped, OUT_VALID=0, PTR=0. No D_READY is asserted in that cycle, so no producer believes it transferred.
- N=1: PTR is constant 0, OUT_SEL=0, and the block behaves as a one-stage pipeline register.
- Fairness: each continuously valid channel is granted at least once every N transfers.
- Producers must hold D_IN and D_VALID stable until their D_READY is seen. The block does not check this.

Optional Feature:
- Macro MUX_RR_FAIR_EN.
- Defined: round-robin arbitration exactly as described above.
- Not defined:
  - Fixed priority: G = lowest index k with D_VALID[k]=1.
  - PTR is not implemented; synthesis removes it.
  - All other behaviour, including latency, handshake and reset values, is identical.

Test Plan:
1. Reset with all D_VALID=1 and OUT_READY=1 for 2 cycles -> D_READY=0000, OUT_VALID=0, D_OUT=0, OUT_SEL=0. First post-reset grant goes to channel 0.
2. N=4, MUX_RR_FAIR_EN defined, all four channels continuously valid with data 0xA0..0xA3, OUT_READY=1 -> outputs 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 on consecutive cycles with OUT_SEL 0,1,2,3,0. OUT_VALID held at 1 with no bubbles.
3. Channels 1 and 3 valid; hold OUT_READY=0 for 3 cycles after the first load -> D_OUT=D_IN[1] and OUT_SEL=1 stable, all D_READY=0. On release, the next word is from channel 3.
4. Only channel 2 valid for a single cycle (data 0x55), OUT_READY=1 -> D_OUT=0x55, OUT_SEL=2, OUT_VALID=1 for exactly one cycle, then 0. D_OUT then holds 0x55.
5. MUX_RR_FAIR_EN undefined, channels 0 and 2 continuously valid -> channel 0 granted every cycle and channel 2 never granted. Drop D_VALID[0] -> channel 2 is granted on the next cycle.
6. Assert RST in the cycle OUT_VALID=1 with OUT_READY=0 -> next cycle OUT_VALID=0 and PTR=0. No D_READY is asserted in the reset cycle.
